// File: rtl/vx_tag_sched.sv
// -----------------------------------------------------------------------------
// vx_tag_sched
//
// Per-bank scheduler in front of the VX_tag_access tag store. It walks every
// line of the bank issuing flushes after reset and whenever a flush is
// requested. Outside a walk it arbitrates the single tag port between fills
// (memory responses, higher priority) and lookups (core requests). Lookup
// responses come back one cycle after the grant, which lines them up with the
// tag store's registered read.
//
// Ports:
//   clk_i            clock
//   reset_ni         asynchronous active-low reset
//   flush_req_i      single-cycle pulse requesting a full-bank flush
//   flush_busy_o     flush walk in progress
//   fill_valid_i     fill request, fill_addr_i its line address
//   fill_ready_o     fill accepted this cycle
//   lookup_valid_i   lookup request, lookup_addr_i its line address
//   lookup_ready_o   lookup accepted this cycle
//   stall_i          downstream pipeline stall
//   tag_lookup_o / tag_fill_o / tag_flush_o / tag_addr_o / tag_stall_o
//                    command interface to the tag store
//   tag_match_i      tag store match, valid the cycle after a lookup
//   rsp_valid_o      lookup response valid
//   rsp_hit_o        lookup hit
//   rsp_addr_o       line address of the responded lookup
// -----------------------------------------------------------------------------
module vx_tag_sched #(
    parameter int CACHE_SIZE      = 16384,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int NUM_BANKS       = 4,
    parameter int LINE_ADDR_WIDTH = 26
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       flush_req_i,
    output logic                       flush_busy_o,
    input  logic                       fill_valid_i,
    input  logic [LINE_ADDR_WIDTH-1:0] fill_addr_i,
    output logic                       fill_ready_o,
    input  logic                       lookup_valid_i,
    input  logic [LINE_ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                       lookup_ready_o,
    input  logic                       stall_i,
    output logic                       tag_lookup_o,
    output logic                       tag_fill_o,
    output logic                       tag_flush_o,
    output logic [LINE_ADDR_WIDTH-1:0] tag_addr_o,
    output logic                       tag_stall_o,
    input  logic                       tag_match_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_hit_o,
    output logic [LINE_ADDR_WIDTH-1:0] rsp_addr_o
);

    localparam int LINES_PER_BANK   = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
    localparam int LINE_SELECT_BITS = $clog2(LINES_PER_BANK);
    localparam logic [LINE_SELECT_BITS-1:0] CNT_LAST = LINE_SELECT_BITS'(LINES_PER_BANK - 1);

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e                       state_q,         state_d;
    logic [LINE_SELECT_BITS-1:0]  cnt_q,           cnt_d;
    logic                         flush_pending_q, flush_pending_d;
    logic                         rsp_valid_q,     rsp_valid_d;
    logic [LINE_ADDR_WIDTH-1:0]   rsp_addr_q,      rsp_addr_d;

    logic fill_grant;
    logic lookup_grant;

    // ------------------------------------------------------------------
    // Tag port arbitration and command generation
    // ------------------------------------------------------------------
    always_comb begin
        fill_grant   = 1'b0;
        lookup_grant = 1'b0;
        tag_flush_o  = 1'b0;
        tag_addr_o   = lookup_addr_i;
        if (state_q == ST_FLUSH) begin
            tag_flush_o = !stall_i;
            // Address holds on the current line while stalled.
            tag_addr_o  = {{(LINE_ADDR_WIDTH-LINE_SELECT_BITS){1'b0}}, cnt_q};
        end else begin
            fill_grant   = !stall_i && fill_valid_i;
            lookup_grant = !stall_i && lookup_valid_i && !fill_valid_i;
            if (fill_grant) begin
                tag_addr_o = fill_addr_i;
            end
        end
    end

    assign fill_ready_o   = fill_grant;
    assign lookup_ready_o = lookup_grant;
    assign tag_fill_o     = fill_grant;
    assign tag_lookup_o   = lookup_grant;
    assign tag_stall_o    = stall_i;
    assign flush_busy_o   = (state_q == ST_FLUSH);

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_addr_o  = rsp_addr_q;
    // The tag store freezes its read data under stall, so gating the live
    // match with the held valid keeps the hit stable too.
    assign rsp_hit_o   = rsp_valid_q && tag_match_i;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        flush_pending_d = flush_pending_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_addr_d      = rsp_addr_q;

        if (stall_i) begin
            // Only the pending request may be recorded during a stall.
            if (flush_req_i) begin
                flush_pending_d = 1'b1;
            end
        end else begin
            rsp_valid_d = lookup_grant;
            if (lookup_grant) begin
                rsp_addr_d = lookup_addr_i;
            end

            if (state_q == ST_FLUSH) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // A request arriving on the last line still earns a
                    // fresh walk rather than being silently absorbed.
                    if (flush_pending_q || flush_req_i) begin
                        flush_pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (flush_req_i) begin
                    flush_pending_d = 1'b1;
                end
            end else begin
                if (flush_req_i || flush_pending_q) begin
                    state_d         = ST_FLUSH;
                    cnt_d           = '0;
                    flush_pending_d = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= ST_FLUSH;
            cnt_q           <= '0;
            flush_pending_q <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_addr_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            flush_pending_q <= flush_pending_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_addr_q      <= rsp_addr_d;
        end
    end

endmodule

// File: tb/tb_vx_tag_sched.sv
module tb_vx_tag_sched;

    localparam int AW = 26;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush_req;
    logic          flush_busy;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic          fill_ready;
    logic          lookup_valid;
    logic [AW-1:0] lookup_addr;
    logic          lookup_ready;
    logic          stall;
    logic          tag_lookup;
    logic          tag_fill;
    logic          tag_flush;
    logic [AW-1:0] tag_addr;
    logic          tag_stall;
    logic          tag_match;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [AW-1:0] rsp_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_tag_sched dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .flush_req_i    (flush_req),
        .flush_busy_o   (flush_busy),
        .fill_valid_i   (fill_valid),
        .fill_addr_i    (fill_addr),
        .fill_ready_o   (fill_ready),
        .lookup_valid_i (lookup_valid),
        .lookup_addr_i  (lookup_addr),
        .lookup_ready_o (lookup_ready),
        .stall_i        (stall),
        .tag_lookup_o   (tag_lookup),
        .tag_fill_o     (tag_fill),
        .tag_flush_o    (tag_flush),
        .tag_addr_o     (tag_addr),
        .tag_stall_o    (tag_stall),
        .tag_match_i    (tag_match),
        .rsp_valid_o    (rsp_valid),
        .rsp_hit_o      (rsp_hit),
        .rsp_addr_o     (rsp_addr)
    );

    // Behavioural tag store: 64 lines, tag = addr[25:6], registered match
    // that holds while stalled.
    logic [19:0] tags [64];
    logic [63:0] vld = '0;
    logic        match_q = 1'b0;
    assign tag_match = match_q;

    always @(posedge clk) begin
        if (!tag_stall) begin
            if (tag_flush) vld[tag_addr[5:0]] <= 1'b0;
            if (tag_fill) begin
                vld[tag_addr[5:0]]  <= 1'b1;
                tags[tag_addr[5:0]] <= tag_addr[25:6];
            end
            match_q <= tag_lookup && vld[tag_addr[5:0]] && (tags[tag_addr[5:0]] == tag_addr[25:6]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follow one flush sequence until flush_busy drops. stall_at: line at
    // which 5 stall cycles are inserted; req_at: line at which flush_req is
    // pulsed. Checks every issued address and the total cycle counts.
    task automatic walk(input int stall_at, input int req_at,
                        input int exp_unstalled, input int exp_cycles);
        int e = 0;
        int uns = 0;
        int cyc = 0;
        int st = 0;
        bit req_done = 0;
        #1;
        check("walk_busy_start", 32'(flush_busy), 32'd1);
        while (flush_busy && cyc < 400) begin
            if (e == stall_at && st < 5) begin
                stall = 1'b1;
                st++;
            end else begin
                stall = 1'b0;
            end
            flush_req = (e == req_at && !req_done && !stall);
            if (flush_req) req_done = 1;
            #1;
            check("walk_addr", 32'(tag_addr), 32'(e));
            check("walk_flush", 32'(tag_flush), 32'(!stall));
            check("walk_ready", {30'd0, fill_ready, lookup_ready}, 32'd0);
            if (!stall) begin
                uns++;
                e = (e + 1) % 64;
            end
            cyc++;
            step();
            flush_req = 1'b0;
            stall = 1'b0;
        end
        check("walk_unstalled", 32'(uns), 32'(exp_unstalled));
        check("walk_cycles", 32'(cyc), 32'(exp_cycles));
        check("walk_busy_end", 32'(flush_busy), 32'd0);
        $display("walk done: unstalled=%0d cycles=%0d", uns, cyc);
    endtask

    initial begin
        reset_n = 1'b0; flush_req = 1'b0; stall = 1'b0;
        fill_valid = 1'b0; fill_addr = '0; lookup_valid = 1'b0; lookup_addr = '0;

        // Reset state
        #2;
        check("rst_busy", 32'(flush_busy), 32'd1);
        check("rst_ready", {30'd0, fill_ready, lookup_ready}, 32'd0);
        check("rst_tag_flush", 32'(tag_flush), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_addr", 32'(rsp_addr), 32'd0);
        stall = 1'b1;
        #1;
        check("rst_tag_flush_stall", 32'(tag_flush), 32'd0);
        check("rst_tag_stall", 32'(tag_stall), 32'd1);
        stall = 1'b0;
        $display("reset state checked");

        // Post-reset walk with both requesters active
        step();
        reset_n = 1'b1;
        fill_valid = 1'b1; lookup_valid = 1'b1;
        walk(-1, -1, 64, 64);
        fill_valid = 1'b0; lookup_valid = 1'b0;

        // Fill then lookup hit, then same-index different-tag miss
        fill_valid = 1'b1; fill_addr = 26'h1234;
        #1;
        check("fill_ready", 32'(fill_ready), 32'd1);
        check("fill_tag_fill", 32'(tag_fill), 32'd1);
        check("fill_tag_addr", 32'(tag_addr), 32'h1234);
        step();
        fill_valid = 1'b0; lookup_valid = 1'b1; lookup_addr = 26'h1234;
        #1;
        check("lk1_ready", 32'(lookup_ready), 32'd1);
        check("lk1_tag_lookup", 32'(tag_lookup), 32'd1);
        step();
        lookup_addr = 26'h5234;
        #1;
        check("lk1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lk1_rsp_hit", 32'(rsp_hit), 32'd1);
        check("lk1_rsp_addr", 32'(rsp_addr), 32'h1234);
        check("lk2_ready", 32'(lookup_ready), 32'd1);
        step();
        lookup_valid = 1'b0;
        #1;
        check("lk2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("lk2_rsp_hit", 32'(rsp_hit), 32'd0);
        check("lk2_rsp_addr", 32'(rsp_addr), 32'h5234);
        check("idle_no_grant", {29'd0, tag_lookup, tag_fill, tag_flush}, 32'd0);
        step();
        check("rsp_clear", 32'(rsp_valid), 32'd0);
        $display("fill/lookup sequence checked");

        // Simultaneous fill and lookup: fill wins
        fill_valid = 1'b1; fill_addr = 26'h40; lookup_valid = 1'b1; lookup_addr = 26'h40;
        #1;
        check("sim_fill_ready", 32'(fill_ready), 32'd1);
        check("sim_lookup_ready", 32'(lookup_ready), 32'd0);
        step();
        fill_valid = 1'b0;
        #1;
        check("sim_lookup_next", 32'(lookup_ready), 32'd1);
        check("sim_no_rsp_for_fill", 32'(rsp_valid), 32'd0);
        step();
        lookup_valid = 1'b0;
        #1;
        check("sim_rsp_hit", 32'(rsp_hit), 32'd1);
        check("sim_rsp_addr", 32'(rsp_addr), 32'h40);
        step();
        $display("fill priority checked");

        // Stall the cycle after a lookup grant: response holds
        lookup_valid = 1'b1; lookup_addr = 26'h1234;
        step();
        stall = 1'b1; lookup_addr = 26'h5234;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stl_lookup_ready", 32'(lookup_ready), 32'd0);
            check("stl_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stl_rsp_addr", 32'(rsp_addr), 32'h1234);
            check("stl_rsp_hit", 32'(rsp_hit), 32'd1);
            step();
        end
        stall = 1'b0; lookup_valid = 1'b0;
        #1;
        check("stl_release_valid", 32'(rsp_valid), 32'd1);
        step();
        check("stl_release_clear", 32'(rsp_valid), 32'd0);
        $display("response stall checked");

        // flush_req during stall in IDLE is deferred until stall drops
        stall = 1'b1; flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("pend_busy_stalled", 32'(flush_busy), 32'd0);
        step();
        check("pend_busy_still", 32'(flush_busy), 32'd0);
        stall = 1'b0;
        step();
        // Walk with 5 stall cycles at line 10
        walk(10, -1, 64, 69);

        // flush_req in IDLE with a fill granted the same cycle, then a
        // request at line 30 forcing a second walk
        fill_valid = 1'b1; fill_addr = 26'h80; flush_req = 1'b1;
        #1;
        check("req_fill_ready", 32'(fill_ready), 32'd1);
        step();
        fill_valid = 1'b0; flush_req = 1'b0;
        walk(-1, 30, 128, 128);

        // Async reset in the middle of a walk
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 40; i++) step();
        check("mid_addr_40", 32'(tag_addr), 32'd40);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_busy", 32'(flush_busy), 32'd1);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_addr", 32'(tag_addr), 32'd0);
        step();
        reset_n = 1'b1;
        walk(-1, -1, 64, 64);
        $display("async reset checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_tag_sched.md
Name: VX_tag_sched

Overview:
- Per-bank scheduler sitting in front of the VX_tag_access tag store.
- Sequences a full-bank flush walk after reset and on request.
- Arbitrates the single tag port between fill (memory response) and lookup (core request) traffic.
- Returns one-cycle-delayed lookup hit/miss responses aligned with the tag store's registered read.

Parameters:
- CACHE_SIZE, 16384: cache size in bytes.
- CACHE_LINE_SIZE, 64: line size in bytes.
- NUM_BANKS, 4: number of banks.
- LINE_ADDR_WIDTH, 26: width of line address.
- Derived: LINES_PER_BANK = CACHE_SIZE/(CACHE_LINE_SIZE*NUM_BANKS), default 64.
- Derived: LINE_SELECT_BITS = clog2(LINES_PER_BANK), default 6.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- flush_req  in  1  single-cycle pulse requesting a full-bank flush.
- flush_busy  out  1  flush walk in progress.
- fill_valid  in  1  fill request.
- fill_addr  in  LINE_ADDR_WIDTH  fill line address.
- fill_ready  out  1  fill accepted this cycle.
- lookup_valid  in  1  lookup request.
- lookup_addr  in  LINE_ADDR_WIDTH  lookup line address.
- lookup_ready  out  1  lookup accepted this cycle.
- stall  in  1  downstream pipeline stall.
- tag_lookup  out  1  to tag store.
- tag_fill  out  1  to tag store.
- tag_flush  out  1  to tag store.
- tag_addr  out  LINE_ADDR_WIDTH  to tag store.
- tag_stall  out  1  to tag store.
- tag_match  in  1  from tag store (valid the cycle after a lookup).
- rsp_valid  out  1  lookup response valid.
- rsp_hit  out  1  lookup hit.
- rsp_addr  out  LINE_ADDR_WIDTH  address of the responded lookup.

Behaviour:
- **State machine:** two states, FLUSH and IDLE. Registers: line counter (LINE_SELECT_BITS), flush_pending, rsp_valid, rsp_addr.
- **Reset (reset=0, asynchronous):**
  - State=FLUSH, counter=0, flush_pending=0, rsp_valid=0.
  - Outputs during reset: flush_busy=1; fill_ready=lookup_ready=tag_lookup=tag_fill=0; tag_flush=!stall; rsp_hit=0; rsp_addr=0.
- **tag_stall:** tag_stall=stall, combinational passthrough. While stall=1, no grants occur and no register other than flush_pending changes.
- **FLUSH state:**
  - Each cycle with stall=0: tag_flush=1, tag_addr={zeros, counter}, counter+1.
  - After issuing counter==LINES_PER_BANK-1: go to IDLE, or, if flush_pending=1, restart at counter=0 and clear flush_pending.
  - A walk takes exactly LINES_PER_BANK unstalled cycles.
  - fill_ready=lookup_ready=0. flush_busy=1.
  - flush_req in FLUSH sets flush_pending. It does not restart the walk mid-way.
- **IDLE state:**
  - fill_ready = !stall && fill_valid. Fill has priority.
  - lookup_ready = !stall && lookup_valid && !fill_valid.
  - Granted fill: tag_fill=1, tag_addr=fill_addr.
  - Granted lookup: tag_lookup=1, tag_addr=lookup_addr.
  - No grant: tag_addr=lookup_addr, and tag_lookup/tag_fill/tag_flush=0.
- **flush_req in IDLE (stall=0):** that cycle's grant still proceeds; next state FLUSH with counter=0.
- **flush_req in IDLE with stall=1:** latched into flush_pending; FLUSH is entered on the first unstalled cycle, and pending is cleared on entry.
- **Response path (lookup granted at cycle T):**
  - rsp_valid=1 at T+1, rsp_addr=lookup_addr registered, rsp_hit = rsp_valid && tag_match (combinational).
  - If stall=1 at T+1, rsp_valid/rsp_addr hold. The tag store holds its read, so rsp_hit is stable.
  - rsp_valid clears on any unstalled cycle without a lookup grant.
  - Fills and flushes never produce a response.
- **Back-to-back lookups:** one per unstalled cycle, responses in order.
- **Counter:** wraps at LINES_PER_BANK-1. LINES_PER_BANK is a power of two.

Test Plan:
- **Post-reset walk:** release reset with stall=0 → tag_flush=1 for 64 consecutive cycles, tag_addr 0..63, then flush_busy=0; fill/lookup_ready stay 0 throughout.
- **Fill then lookup:** fill addr 0x1234, then lookup 0x1234, with tag store model → rsp_valid one cycle after the lookup grant, rsp_hit=1, rsp_addr=0x1234. A lookup of 0x5234 (same line index, different tag) → rsp_hit=0.
- **Simultaneous fill_valid and lookup_valid:** → fill granted first (fill_ready=1, lookup_ready=0); lookup granted the next cycle.
- **Stall during walk:** stall=1 for 5 cycles at counter=10 → tag_addr holds 10, no counter advance; the walk completes in 64+5 cycles. Stall at T+1 after a lookup → rsp_valid/rsp_addr held until stall drops.
- **flush_req mid-walk at counter=30:** → walk completes to 63, restarts at 0 for a second full walk, 128 total unstalled cycles, then IDLE.
- **Async reset asserted mid-walk at counter=40:** → immediate flush_busy=1, rsp_valid=0; the walk restarts at 0 after release.
